// File: rtl/tone_pkg.sv
// tone_pkg: pitch table, envelope state encoding and build defaults shared by note_tone_gen
// (the optional drop counter port of note_tone_gen is enabled by TONE_DROP_COUNT_EN)
package tone_pkg;

   localparam int CLOCK_HZ     = 50000000;
   localparam int SAMPLE_RATE  = 48000;
   // Rounded clocks per audio sample: 1042 at 50 MHz
   localparam int SAMPLE_DIV_DEF = (CLOCK_HZ + SAMPLE_RATE / 2) / SAMPLE_RATE;
   localparam int SAMPLE_W_DEF   = 32;
   localparam int AMP_W_DEF      = 24;
   localparam int ENV_STEP_DEF   = 8192;
   localparam int NOTE_W         = 9;
   localparam int PHASE_W        = 17;

   // Half periods in clocks at CLOCK_HZ
   localparam logic [PHASE_W-1:0] HP_C4 = 17'd95556;
   localparam logic [PHASE_W-1:0] HP_D4 = 17'd85131;
   localparam logic [PHASE_W-1:0] HP_E4 = 17'd75843;
   localparam logic [PHASE_W-1:0] HP_F4 = 17'd71586;
   localparam logic [PHASE_W-1:0] HP_G4 = 17'd63776;
   localparam logic [PHASE_W-1:0] HP_A4 = 17'd56818;
   localparam logic [PHASE_W-1:0] HP_B4 = 17'd50619;
   localparam logic [PHASE_W-1:0] HP_C5 = 17'd47778;
   localparam logic [PHASE_W-1:0] HP_D5 = 17'd42566;

   localparam logic [1:0] ENV_IDLE    = 2'd0;
   localparam logic [1:0] ENV_ATTACK  = 2'd1;
   localparam logic [1:0] ENV_SUSTAIN = 2'd2;
   localparam logic [1:0] ENV_RELEASE = 2'd3;

   typedef enum logic [1:0] {
      IDLE    = ENV_IDLE,
      ATTACK  = ENV_ATTACK,
      SUSTAIN = ENV_SUSTAIN,
      RELEASE = ENV_RELEASE
   } env_state_t;

   // Note index 0 is C4 (key q), index 8 is D5 (key o)
   function automatic logic [PHASE_W-1:0] half_period(input logic [3:0] idx);
      case (idx)
         4'd0:    half_period = HP_C4;
         4'd1:    half_period = HP_D4;
         4'd2:    half_period = HP_E4;
         4'd3:    half_period = HP_F4;
         4'd4:    half_period = HP_G4;
         4'd5:    half_period = HP_A4;
         4'd6:    half_period = HP_B4;
         4'd7:    half_period = HP_C5;
         4'd8:    half_period = HP_D5;
         default: half_period = HP_C4;
      endcase
   endfunction

endpackage

// File: rtl/tone_envelope.sv
// tone_envelope: linear attack/release envelope FSM and amplitude register, advanced on sample ticks
module tone_envelope
   import tone_pkg::*;
#(
   parameter int AMP_W    = AMP_W_DEF,
   parameter int ENV_STEP = ENV_STEP_DEF
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             i_tick,
   input  logic             i_note_valid,
   output logic [AMP_W-1:0] o_amplitude,
   output logic [1:0]       o_env_state
);

   localparam logic [AMP_W-1:0] AMP_MAX = {1'b0, {(AMP_W-1){1'b1}}};
   localparam logic [AMP_W:0]   STEP    = (AMP_W+1)'(ENV_STEP);

   env_state_t       r_state;
   env_state_t       w_state_nxt;
   logic [AMP_W-1:0] r_amp;
   logic [AMP_W-1:0] w_amp_nxt;
   logic [AMP_W-1:0] w_amp_up;
   logic [AMP_W-1:0] w_amp_dn;
   logic [AMP_W:0]   w_sum;

   assign w_sum    = {1'b0, r_amp} + STEP;
   assign w_amp_up = (w_sum >= {1'b0, AMP_MAX}) ? AMP_MAX : w_sum[AMP_W-1:0];
   assign w_amp_dn = ({1'b0, r_amp} > STEP) ? r_amp - STEP[AMP_W-1:0] : '0;

   // Next state and amplitude as they would be after the coming tick
   always_comb begin
      w_state_nxt = r_state;
      w_amp_nxt   = r_amp;
      case (r_state)
         IDLE: begin
            w_amp_nxt = '0;
            if (i_note_valid) w_state_nxt = ATTACK;
         end
         ATTACK: begin
            if (!i_note_valid) w_state_nxt = RELEASE;
            else begin
               w_amp_nxt = w_amp_up;
               if (w_amp_up == AMP_MAX) w_state_nxt = SUSTAIN;
            end
         end
         SUSTAIN: if (!i_note_valid) w_state_nxt = RELEASE;
         RELEASE: begin
            if (i_note_valid) w_state_nxt = ATTACK;
            else begin
               w_amp_nxt = w_amp_dn;
               if (w_amp_dn == '0) w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // State and amplitude only move on the sample tick
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= IDLE;
         r_amp   <= '0;
      end else if (i_tick) begin
         r_state <= w_state_nxt;
         r_amp   <= w_amp_nxt;
      end
   end

   // Post-update amplitude so a sample loaded on a tick reflects that tick's step
   assign o_amplitude = w_amp_nxt;
   assign o_env_state = r_state;

endmodule

// File: rtl/note_tone_gen.sv
// note_tone_gen: one-hot note to enveloped square-wave samples over valid/ready
// (define TONE_DROP_COUNT_EN to add the saturating drop_count output)
module note_tone_gen
   import tone_pkg::*;
#(
   parameter int SAMPLE_DIV = SAMPLE_DIV_DEF,
   parameter int SAMPLE_W   = SAMPLE_W_DEF,
   parameter int AMP_W      = AMP_W_DEF,
   parameter int ENV_STEP   = ENV_STEP_DEF
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [NOTE_W-1:0]   note,
   input  logic                sample_ready,
   output logic                sample_valid,
   output logic [SAMPLE_W-1:0] sample,
   output logic [1:0]          env_state,
   output logic                note_active
`ifdef TONE_DROP_COUNT_EN
   ,
   output logic [7:0]          drop_count
`endif
);

   localparam int DIV_W = $clog2(SAMPLE_DIV);

   logic                  w_dec_valid;
   logic [3:0]            w_dec_idx;
   logic                  r_note_valid;
   logic [3:0]            r_note_idx;
   logic                  w_phase_clr;
   logic [PHASE_W-1:0]    w_half;
   logic [PHASE_W-1:0]    r_phase;
   logic                  r_neg;
   logic [DIV_W-1:0]      r_div;
   logic                  w_tick;
   logic [AMP_W-1:0]      w_amp;
   logic [1:0]            w_env_state;
   logic signed [AMP_W:0] w_val;
   logic [SAMPLE_W-1:0]   w_sample;
   logic                  w_load;
   logic                  r_valid;
   logic [SAMPLE_W-1:0]   r_sample;

   // Key index of the set bit; bit 8 (q) is C4, bit 0 (o) is D5
   always_comb begin
      w_dec_idx = '0;
      for (int i = 0; i < NOTE_W; i++)
         if (note[i]) w_dec_idx = 4'(NOTE_W - 1 - i);
   end

   assign w_dec_valid = $onehot(note);
   // Restart the waveform whenever a valid note appears that differs from the decoded one
   assign w_phase_clr = w_dec_valid && (!r_note_valid || w_dec_idx != r_note_idx);
   assign w_half      = half_period(r_note_idx);
   assign w_tick      = (r_div == DIV_W'(SAMPLE_DIV - 1));

   // Registered note decode; the last valid pitch is kept so release keeps its tone
   always_ff @(posedge clock) begin
      if (reset) begin
         r_note_valid <= 1'b0;
         r_note_idx   <= '0;
      end else begin
         r_note_valid <= w_dec_valid;
         if (w_dec_valid) r_note_idx <= w_dec_idx;
      end
   end

   // Square-wave phase: toggle polarity every half period, restart positive on a new note
   always_ff @(posedge clock) begin
      if (reset || w_phase_clr) begin
         r_phase <= '0;
         r_neg   <= 1'b0;
      end else if (r_phase == w_half - 1'b1) begin
         r_phase <= '0;
         r_neg   <= ~r_neg;
      end else begin
         r_phase <= r_phase + 1'b1;
      end
   end

   // Sample-rate divider, tick is the wrap cycle
   always_ff @(posedge clock) begin
      if (reset) r_div <= '0;
      else       r_div <= w_tick ? '0 : r_div + 1'b1;
   end

   tone_envelope #(
      .AMP_W    (AMP_W),
      .ENV_STEP (ENV_STEP)
   ) u_env (
      .clock        (clock),
      .reset        (reset),
      .i_tick       (w_tick),
      .i_note_valid (r_note_valid),
      .o_amplitude  (w_amp),
      .o_env_state  (w_env_state)
   );

   assign w_val    = r_neg ? -$signed({1'b0, w_amp}) : $signed({1'b0, w_amp});
   assign w_sample = SAMPLE_W'(w_val);
   // A tick only loads when the output slot is empty or being emptied this cycle
   assign w_load   = w_tick && (!r_valid || sample_ready);

   // Output holding register; holds steady while the codec is not ready
   always_ff @(posedge clock) begin
      if (reset) begin
         r_valid  <= 1'b0;
         r_sample <= '0;
      end else if (w_load) begin
         r_valid  <= 1'b1;
         r_sample <= w_sample;
      end else if (sample_ready) begin
         r_valid  <= 1'b0;
      end
   end

`ifdef TONE_DROP_COUNT_EN
   logic [7:0] r_drop_count;

   // Count ticks whose sample was discarded because the previous one was still held
   always_ff @(posedge clock) begin
      if (reset) r_drop_count <= '0;
      else if (w_tick && r_valid && !sample_ready && r_drop_count != 8'hFF)
         r_drop_count <= r_drop_count + 1'b1;
   end

   assign drop_count = r_drop_count;
`endif

   assign sample_valid = r_valid;
   assign sample       = r_sample;
   assign env_state    = w_env_state;
   assign note_active  = (w_env_state != ENV_IDLE);

endmodule

// File: tb/tb_note_tone_gen.sv
// tb_note_tone_gen: scoreboard bench with a cycle-level behavioural model of note_tone_gen
module tb_note_tone_gen;

   localparam int DIV  = 64;
   localparam int STEP = 1 << 20;
   localparam int AMAX = (1 << 23) - 1;

   int hp [9] = '{95556, 85131, 75843, 71586, 63776, 56818, 50619, 47778, 42566};

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [8:0]  note = '0;
   logic        sample_ready = 1'b1;
   logic        sample_valid;
   logic [31:0] sample;
   logic [1:0]  env_state;
   logic        note_active;
`ifdef TONE_DROP_COUNT_EN
   logic [7:0]  drop_count;
`endif

   note_tone_gen #(
      .SAMPLE_DIV (DIV),
      .SAMPLE_W   (32),
      .AMP_W      (24),
      .ENV_STEP   (STEP)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .note         (note),
      .sample_ready (sample_ready),
      .sample_valid (sample_valid),
      .sample       (sample),
      .env_state    (env_state),
      .note_active  (note_active)
`ifdef TONE_DROP_COUNT_EN
      ,
      .drop_count   (drop_count)
`endif
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   task automatic chk(string nm, int act, int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
      end
   endtask

   task automatic cyc(int k);
      repeat (k) @(posedge clock);
      #1;
   endtask

   // Behavioural model: absolute clock count, elapsed-time polarity, plain envelope arithmetic
   int n = 0, n0 = 0, half = 95556;
   int m_div = 0, m_amp = 0, m_env = 0, m_valid = 0;
   int m_dvalid = 0, m_didx = 0, m_drops = 0, m_xfers = 0;
   int m_ev = 0, m_rst = 0;
   int expq[$];
   int v, idx, val;
   bit tick;

   always @(posedge clock) begin
      n++;
      m_ev  = 0;
      m_rst = 0;
      if (m_valid && sample_ready) m_xfers++;
      if (reset) begin
         m_div = 0; m_amp = 0; m_env = 0; m_valid = 0;
         m_dvalid = 0; m_didx = 0; m_drops = 0;
         n0 = n; half = hp[0];
         expq.delete();
         m_ev = 1; m_rst = 1;
      end else begin
         tick = (m_div == DIV - 1);
         if (tick) begin
            v = m_dvalid;
            case (m_env)
               0: begin m_amp = 0; if (v) m_env = 1; end
               1: if (!v) m_env = 3;
                  else begin
                     m_amp = (m_amp + STEP > AMAX) ? AMAX : m_amp + STEP;
                     if (m_amp == AMAX) m_env = 2;
                  end
               2: if (!v) m_env = 3;
               default: if (v) m_env = 1;
                  else begin
                     m_amp = (m_amp > STEP) ? m_amp - STEP : 0;
                     if (m_amp == 0) m_env = 0;
                  end
            endcase
            val = (((n - 1 - n0) / half) % 2 == 1) ? -m_amp : m_amp;
            if (!m_valid || sample_ready) begin
               expq.push_back(val);
               m_valid = 1;
            end else if (m_drops < 255) m_drops++;
            m_ev = 1;
         end else if (m_valid && sample_ready) begin
            m_valid = 0;
            m_ev = 1;
         end
         v = ($countones(note) == 1) ? 1 : 0;
         idx = 0;
         for (int i = 0; i < 9; i++) if (note[i]) idx = 8 - i;
         if (v == 1 && (m_dvalid == 0 || idx != m_didx)) begin
            n0 = n;
            half = hp[idx];
         end
         m_dvalid = v;
         if (v == 1) m_didx = idx;
         m_div = tick ? 0 : m_div + 1;
      end
   end

   // Monitor: pop on every transfer, check handshake/state after model events
   int mon_pops = 0;
   int exp_s;

   always @(negedge clock) begin
      if (sample_valid === 1'b1 && sample_ready === 1'b1) begin
         mon_pops++;
         if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL xfer_unexpected got=%0d exp=none", $signed(sample));
         end else begin
            exp_s = expq.pop_front();
            chk("sample", $signed(sample), exp_s);
         end
      end
      if (m_ev == 1) begin
         chk("valid", int'(sample_valid), m_valid);
         chk("env_state", int'(env_state), m_env);
         chk("note_active", int'(note_active), (m_env != 0) ? 1 : 0);
      end
      if (m_rst == 1) chk("reset_sample", $signed(sample), 0);
   end

   int nsel;

   initial begin
      cyc(5);
      chk("rst_valid", int'(sample_valid), 0);
      chk("rst_sample", $signed(sample), 0);
      chk("rst_env", int'(env_state), 0);
      chk("rst_active", int'(note_active), 0);
      reset = 1'b0;
      cyc(3000);
      chk("silence_env", int'(env_state), 0);

      note = 9'b000001000;
      cyc(57500);
      chk("a4_sustain", int'(env_state), 2);

      note = 9'b000000010;
      cyc(2000);
      chk("c5_sustain", int'(env_state), 2);

      sample_ready = 1'b0;
      cyc(3 * DIV);
      chk("hold_valid", int'(sample_valid), 1);
      sample_ready = 1'b1;
      cyc(500);

      note = 9'b000000000;
      cyc(12 * DIV);
      chk("release_done", int'(env_state), 0);

      note = 9'b000001000;
      cyc(5 * DIV);
      chk("attack", int'(env_state), 1);
      note = 9'b100000001;
      cyc(DIV + 2);
      chk("two_bits_release", int'(env_state), 3);
      reset = 1'b1;
      cyc(1);
      chk("mid_rst_valid", int'(sample_valid), 0);
      chk("mid_rst_sample", $signed(sample), 0);
      chk("mid_rst_env", int'(env_state), 0);
      chk("mid_rst_active", int'(note_active), 0);
      reset = 1'b0;

      for (int s = 0; s < 30; s++) begin
         nsel = $urandom_range(0, 11);
         if (nsel < 9)        note = 9'(1 << nsel);
         else if (nsel == 9)  note = '0;
         else if (nsel == 10) note = 9'b100000001 | 9'(1 << $urandom_range(1, 7));
         else                 note = 9'($urandom);
         if ($urandom_range(0, 9) == 0) begin
            reset = 1'b1;
            cyc(2);
            reset = 1'b0;
         end
         for (int c = $urandom_range(60, 500); c > 0; c--) begin
            sample_ready = (s % 2 == 1) ? ($urandom_range(0, 2) != 0) : 1'b1;
            cyc(1);
         end
      end
      sample_ready = 1'b1;
      cyc(2 * DIV);

      chk("xfer_count", mon_pops, m_xfers);
`ifdef TONE_DROP_COUNT_EN
      chk("drop_count", int'(drop_count), m_drops);
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/note_tone_gen.md
Name: note_tone_gen

Overview:
- Downstream of the sequencer/sampler stage. Consumes its 9-bit one-hot note vector (q..o keys, also shown on LEDR) and produces signed square-wave audio samples for the audio codec controller's left/right write FIFO.
- Maps each note to a fixed pitch (C4..D5).
- Applies a linear attack/release envelope so note changes do not click.
- Delivers one sample per sample period over a valid/ready handshake.

Parameters:
- CLOCK_HZ, 50000000, system clock frequency; used only to document the constants in the package.
- SAMPLE_DIV, 1042, clocks per audio sample (about 48 kHz at 50 MHz).
- SAMPLE_W, 32, output sample width (codec FIFO width).
- AMP_W, 24, envelope amplitude width, unsigned.
- ENV_STEP, 8192, amplitude increment/decrement per sample tick.

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- note  in  9  one-hot note from sampler; bit8=q=C4 ... bit0=o=D5; zero = silence
- sample_ready  in  1  codec FIFO can accept a sample
- sample_valid  out  1  sample is held and valid
- sample  out  SAMPLE_W  signed two's-complement sample, same value written to L and R
- env_state  out  2  envelope state for debug/LEDs
- note_active  out  1  high when env_state != IDLE

Behaviour:
- Reset: sample_valid=0, sample=0, env_state=IDLE, note_active=0, amplitude=0, tick and phase counters=0, polarity=+.
- Note decode is registered, 1 cycle latency.
  - A valid note is exactly one bit set.
  - Zero, or more than one bit set, is treated as "no note".
- Half-period constants in clocks: C4 95556, D4 85131, E4 75843, F4 71586, G4 63776, A4 56818, B4 50619, C5 47778, D5 42566. Phase counter is 17 bits.
- Phase counter increments every clock. On reaching half_period-1 it wraps to 0 and toggles polarity.
- When the decoded note changes to a different valid note, the phase counter clears and polarity is set to +. Amplitude is kept (legato).
- Sample tick: a divider counts 0..SAMPLE_DIV-1 and pulses tick for one clock on wrap.
- Envelope FSM, which advances only on tick:
  - IDLE: amplitude 0. A valid note goes to ATTACK.
  - ATTACK: amplitude += ENV_STEP, saturating at 2^(AMP_W-1)-1. Goes to SUSTAIN on saturation. With no note, goes to RELEASE.
  - SUSTAIN: holds. With no note, goes to RELEASE.
  - RELEASE: amplitude -= ENV_STEP, floored at 0. At 0 goes to IDLE. A valid note goes back to ATTACK from the current amplitude.
  - Encoding: IDLE=0, ATTACK=1, SUSTAIN=2, RELEASE=3.
- Sample value is +amplitude or -amplitude according to polarity, sign-extended from AMP_W+1 to SAMPLE_W, computed from the post-update amplitude on the same tick.
- Handshake:
  - On tick, if sample_valid=0 or (sample_valid && sample_ready), load sample and set sample_valid=1.
  - A transfer occurs on any clock with sample_valid && sample_ready. If no new tick arrives that cycle, sample_valid falls the next cycle.
  - sample is stable while sample_valid && !sample_ready.
  - Tick while sample_valid && !sample_ready: the new sample is dropped and the held sample is kept.
  - Tick and transfer in the same cycle: the new sample loads and sample_valid stays 1.
- Reset mid-note: everything returns to reset values on the next edge. No sample is emitted that cycle.

Optional Feature:
- Macro: TONE_DROP_COUNT_EN.
- Defined: adds output drop_count (8 bits, reset 0). It increments by 1, saturating at 255, on every tick where a sample is dropped because sample_valid && !sample_ready.
- Undefined: the port is absent and drops are silent. All other behaviour is identical.

Decomposition:
- Package tone_pkg holds:
  - the nine half-period constants and a note-index-to-half-period function
  - env_state encoding localparams
  - the IDLE/ATTACK/SUSTAIN/RELEASE names
- One sub-module, tone_envelope: envelope FSM plus amplitude register, driven by tick and note_valid. It outputs amplitude and env_state.
- Phase counter, divider and handshake stay in note_tone_gen.

Test Plan:
- Reset with note=0 for 3000 clocks, sample_ready=1. Required: sample_valid pulses every 1042 clocks, sample=0 each time, env_state=0.
- note=9'b000001000 (A4), sample_ready=1. Required:
  - env_state=1 from the first tick after decode.
  - amplitude reaches 8388607 after 1024 ticks, then env_state=2.
  - sample sign flips every 56818 clocks (±1 clock).
- Sustain on A4, then note=0. Required: env_state=3, |sample| decreases by 8192 per tick, env_state=0 after 1024 ticks, sample=0 thereafter.
- Switch from A4 to C5 mid-sustain. Required: phase clears and first half-period is 47778 clocks, amplitude unchanged, env_state stays 2.
- Hold sample_ready=0 for 3 ticks. Required:
  - sample_valid stays 1 and sample is unchanged.
  - With TONE_DROP_COUNT_EN, drop_count=2.
  - On ready=1, one transfer, then normal cadence resumes.
- note=9'b100000001 (two bits set) during ATTACK. Required: treated as no note, so RELEASE on the next tick. Then assert reset mid-RELEASE. Required: all outputs return to reset values on the next clock.
